// File: rtl/prog_loader.sv
// Assembles a byte stream big-endian into instruction lines and writes them to the line store from address 0.
// Write strobe follows the last byte of a line by one cycle; in_ready drops during writes and outside a load.
module prog_loader #(
  parameter int                    IP_WIDTH   = 8,
  parameter int                    LINE_WIDTH = 32,
  parameter int                    NUM_LINES  = 255,
  parameter logic [LINE_WIDTH-1:0] TERM       = '1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [IP_WIDTH-1:0]   wr_addr,
  output logic [LINE_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  overflow
);

  localparam int                   BYTES     = LINE_WIDTH / 8;
  localparam int                   CNT_W     = $clog2(BYTES + 1);
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [IP_WIDTH-1:0]  LAST_USER = IP_WIDTH'(NUM_LINES - 1);
  localparam logic [IP_WIDTH-1:0]  TERM_ADDR = IP_WIDTH'(NUM_LINES);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, FORCE_TERM, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IP_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0] shift_q, shift_d, shift_in;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [IP_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [LINE_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  // Truncating the concatenation keeps the newest LINE_WIDTH bits, byte 0 ending at the MSB.
  assign shift_in = LINE_WIDTH'({shift_q, in_data});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    in_ready_d = in_ready_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RECV;
          cnt_d      = '0;
          addr_d     = '0;
          shift_d    = '0;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          cpu_hold_d = 1'b1;
          in_ready_d = 1'b1;
        end
      end
      RECV: begin
        if (in_valid && in_ready_q) begin
          shift_d = shift_in;
          if (cnt_q == LAST_BYTE) begin
            state_d    = WRITE;
            in_ready_d = 1'b0;
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = shift_in;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        addr_d = addr_q + IP_WIDTH'(1);
        cnt_d  = '0;
        if (wr_data_q == TERM) begin
          state_d    = DONE;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else if (addr_q == LAST_USER) begin
          // Store is full: close it with a terminator in the reserved last slot.
          state_d   = FORCE_TERM;
          wr_en_d   = 1'b1;
          wr_addr_d = TERM_ADDR;
          wr_data_d = TERM;
        end else begin
          state_d    = RECV;
          in_ready_d = 1'b1;
        end
      end
      FORCE_TERM: begin
        state_d    = DONE;
        done_d     = 1'b1;
        overflow_d = 1'b1;
        cpu_hold_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: default-size instance plus a NUM_LINES=4 instance for overflow.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start0, start1;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready0, wr_en0, cpu_hold0, done0, overflow0;
  logic [7:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic        in_ready1, wr_en1, cpu_hold1, done1, overflow1;
  logic [7:0]  wr_addr1;
  logic [31:0] wr_data1;

  logic        sel;
  logic        rdy, wen, cph, dn, ovf;
  logic [7:0]  waddr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;
  int wcnt0  = 0;

  prog_loader u0 (
    .clk(clk), .n_rst(n_rst), .start(start0), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .cpu_hold(cpu_hold0), .done(done0), .overflow(overflow0)
  );

  prog_loader #(.NUM_LINES(4)) u1 (
    .clk(clk), .n_rst(n_rst), .start(start1), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .cpu_hold(cpu_hold1), .done(done1), .overflow(overflow1)
  );

  always #5 clk = ~clk;

  always_comb begin
    rdy   = sel ? in_ready1 : in_ready0;
    wen   = sel ? wr_en1    : wr_en0;
    cph   = sel ? cpu_hold1 : cpu_hold0;
    dn    = sel ? done1     : done0;
    ovf   = sel ? overflow1 : overflow0;
    waddr = sel ? wr_addr1  : wr_addr0;
    wdata = sel ? wr_data1  : wr_data0;
  end

  always @(negedge clk) if (wr_en0 === 1'b1) wcnt0++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        chk("wr_en idle while receiving", wen, 0);
        @(posedge clk);
        #1;
        got = 1;
      end
    end
    if (!got) chk("byte accept timeout", 0, 1);
  endtask

  // Returns at the negedge of the write cycle, with the next byte (if any) already presented.
  task automatic send_line(input logic [31:0] w, input logic [7:0] a,
                           input logic has_next, input logic [7:0] nxt);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    in_valid = has_next;
    in_data  = has_next ? nxt : 8'h00;
    @(negedge clk);
    chk("wr_en after last byte", wen, 1);
    chk("wr_addr", waddr, a);
    chk("wr_data", wdata, w);
    chk("in_ready during write", rdy, 0);
  endtask

  task automatic pulse_start(input logic s);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    chk("cpu_hold after start", cph, 1);
    chk("in_ready after start", rdy, 1);
    chk("done cleared by start", dn, 0);
    chk("overflow cleared by start", ovf, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_done(input logic exp_ovf);
    @(negedge clk);
    chk("done level", dn, 1);
    chk("overflow level", ovf, exp_ovf);
    chk("cpu_hold released", cph, 0);
    chk("wr_en after load", wen, 0);
    chk("in_ready in done", rdy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sel      = 1'b0;
    n_rst    = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      in_data  = 8'h5A;
      @(negedge clk);
      chk("reset outputs u0", {wr_en0, in_ready0, cpu_hold0, done0, overflow0, wr_addr0, wr_data0}, 0);
      chk("reset outputs u1", {wr_en1, in_ready1, cpu_hold1, done1, overflow1, wr_addr1, wr_data1}, 0);
    end
    @(posedge clk);
    #1;
    n_rst    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle ignores bytes", rdy, 0);
    chk("idle cpu_hold", cph, 0);

    // Continuous stream; next byte is presented during each WRITE cycle.
    pulse_start(1'b0);
    send_line(32'h0300_0000, 8'd0, 1'b1, 8'h03);
    send_line(32'h0301_0000, 8'd1, 1'b1, 8'hFF);
    send_line(32'hFFFF_FFFF, 8'd2, 1'b0, 8'h00);
    check_done(1'b0);
    chk("write count load 1", wcnt0, 3);

    // Same stream with a 3-cycle bubble between bytes 2 and 3.
    pulse_start(1'b0);
    send_byte(8'h03);
    send_byte(8'h00);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no write in bubble", wen, 0);
      chk("ready held in bubble", rdy, 1);
      @(posedge clk);
      #1;
    end
    send_byte(8'h00);
    send_byte(8'h00);
    in_valid = 1'b1;
    in_data  = 8'h03;
    @(negedge clk);
    chk("bubble line wr_en", wen, 1);
    chk("bubble line addr", waddr, 0);
    chk("bubble line data", wdata, 32'h0300_0000);
    send_line(32'h0301_0000, 8'd1, 1'b1, 8'hFF);
    send_line(32'hFFFF_FFFF, 8'd2, 1'b0, 8'h00);
    check_done(1'b0);
    chk("write count load 2", wcnt0, 6);

    // Overflow on the small instance.
    sel = 1'b1;
    pulse_start(1'b1);
    send_line(32'h0000_0001, 8'd0, 1'b1, 8'h00);
    send_line(32'h0000_0002, 8'd1, 1'b1, 8'h00);
    send_line(32'h0000_0003, 8'd2, 1'b1, 8'h00);
    send_line(32'h0000_0004, 8'd3, 1'b0, 8'h00);
    @(negedge clk);
    chk("force term wr_en", wen, 1);
    chk("force term addr", waddr, 4);
    chk("force term data", wdata, 32'hFFFF_FFFF);
    chk("force term in_ready", rdy, 0);
    chk("force term cpu_hold", cph, 1);
    @(posedge clk);
    #1;
    check_done(1'b1);
    chk("u0 untouched by u1 load", wcnt0, 6);

    // Reset in the middle of a line, then a clean reload.
    sel = 1'b0;
    pulse_start(1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    n_rst = 1'b0;
    #1;
    chk("async cpu_hold drop", cpu_hold0, 0);
    chk("async in_ready drop", in_ready0, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    pulse_start(1'b0);
    send_line(32'h1122_3344, 8'd0, 1'b1, 8'hFF);
    send_line(32'hFFFF_FFFF, 8'd1, 1'b0, 8'h00);
    check_done(1'b0);
    chk("write count after reload", wcnt0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
